// File: rtl/ebpc_pkg.sv
// Shared defaults and state type for the DBP block assembler.
package ebpc_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int BLOCK_SIZE_DEF = 8;

    typedef enum logic {
        WAIT_BASE = 1'b0,
        FILLING   = 1'b1
    } asm_state_e;

endpackage

// File: rtl/dbp_block_fifo.sv
// Small synchronous FIFO holding assembled blocks; output reads as zero while empty.
module dbp_block_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic             full,
    output logic [CW-1:0]    count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_wr;
    logic             do_rd;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Full is taken from the registered count, so a same-cycle pop never frees a slot.
    assign full    = (count == CW'(DEPTH));
    assign valid   = (count != '0);
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & valid;
    assign rd_data = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= bump(wr_ptr);
            if (do_rd) rd_ptr <= bump(rd_ptr);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/dbp_block_assembler.sv
// Collects a base word plus DATA_W+1 delta-bit-plane words into a block and queues it.
module dbp_block_assembler
    import ebpc_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int BLOCK_SIZE = BLOCK_SIZE_DEF,
    parameter int DEPTH      = 2,
    localparam int PW        = BLOCK_SIZE - 1,
    localparam int FW        = $clog2(DEPTH + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clr_i,
    input  logic [DATA_W-1:0]        data_i,
    input  logic                     push_i,
    input  logic                     flush_i,
    output logic                     rdy_o,
    output logic [DATA_W-1:0]        base_o,
    output logic [DATA_W:0][PW-1:0]  dbp_o,
    output logic                     flush_o,
    output logic                     vld_o,
    input  logic                     rdy_i,
    output logic [FW-1:0]            fill_o
);
    localparam int CNTW = $clog2(DATA_W + 2);
    localparam int PLW  = 1 + DATA_W + (DATA_W + 1) * PW;

    asm_state_e              state;
    logic [CNTW-1:0]         cnt;
    logic [DATA_W-1:0]       base;
    logic [DATA_W:0][PW-1:0] sr;
    logic [DATA_W:0][PW-1:0] sr_shift;
    logic                    last_plane;
    logic                    would_write;
    logic                    accept;
    logic                    flush_go;
    logic                    fifo_full;
    logic                    wr_en;
    logic [PLW-1:0]          wr_data;
    logic [PLW-1:0]          rd_data;

    // Newest plane enters at the top entry; entry 0 ends up holding the oldest plane.
    assign sr_shift    = {data_i[DATA_W-1 -: PW], sr[DATA_W:1]};
    assign last_plane  = (state == FILLING) && (cnt == CNTW'(DATA_W));
    assign would_write = flush_i || (push_i && last_plane);
    assign rdy_o       = !(fifo_full && would_write);
    assign accept      = push_i & rdy_o;
    assign flush_go    = flush_i & rdy_o;

    always_comb begin
        wr_en   = 1'b0;
        wr_data = '0;
        if (flush_go) begin
            wr_en = 1'b1;
            if (state == FILLING)
                wr_data = {1'b1, base, accept ? sr_shift : sr};
            else
                wr_data = {1'b1, {(PLW - 1){1'b0}}};
        end else if (accept && last_plane) begin
            wr_en   = 1'b1;
            wr_data = {1'b0, base, sr_shift};
        end
    end

    // A flush seen in WAIT_BASE emits only a marker, so any push alongside it is dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= WAIT_BASE;
            cnt   <= '0;
            base  <= '0;
            sr    <= '0;
        end else if (clr_i) begin
            state <= WAIT_BASE;
            cnt   <= '0;
            base  <= '0;
            sr    <= '0;
        end else begin
            case (state)
                WAIT_BASE: begin
                    if (accept && !flush_i) begin
                        base  <= data_i;
                        sr    <= '0;
                        cnt   <= '0;
                        state <= FILLING;
                    end
                end
                FILLING: begin
                    if (flush_go) begin
                        cnt   <= '0;
                        state <= WAIT_BASE;
                    end else if (accept) begin
                        sr  <= sr_shift;
                        cnt <= cnt + CNTW'(1);
                        if (last_plane) state <= WAIT_BASE;
                    end
                end
                default: state <= WAIT_BASE;
            endcase
        end
    end

    dbp_block_fifo #(
        .WIDTH (PLW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr     (clr_i),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (rdy_i),
        .rd_data (rd_data),
        .valid   (vld_o),
        .full    (fifo_full),
        .count   (fill_o)
    );

    assign {flush_o, base_o, dbp_o} = rd_data;

endmodule
